// File: rtl/mmio_dmem_pkg.sv
// Shared MMIO address map and verdict constants for the data memory block.
package mmio_dmem_pkg;

   localparam logic [31:0] FIFO_PUSH = 32'hFFFF_FFF0;
   localparam logic [31:0] FIFO_STAT = 32'hFFFF_FFF4;
   localparam logic [31:0] TEST_END  = 32'hFFFF_FFFC;
   localparam logic [31:0] PASS_CODE = 32'd1;

endpackage

// File: rtl/mmio_dmem_fifo.sv
// Result FIFO: power-of-two depth, registered output, no bypass.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   // A full FIFO still accepts a push when the head leaves this cycle.
   always_comb begin
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) mem_q[wr_q] <= din;
   end

   assign dout  = mem_q[rd_q];
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/mmio_dmem.sv
// Data RAM with MMIO result FIFO and test-end verdict register.
module mmio_dmem
   import mmio_dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        done,
   output logic        pass,
   output logic        overflow,
   output logic        misalign
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   RAM [DEPTH_WORDS];
   logic [AW-1:0] widx;
   logic          aligned, in_ram;
   logic          ram_we, push_req, end_req;
   logic          f_full, f_empty;
   logic [CW-1:0] f_count;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          ovf_q, ovf_d;
   logic          mis_q, mis_d;

   assign widx     = dataadr[AW+1:2];
   assign aligned  = (dataadr[1:0] == 2'b00);
   assign in_ram   = (dataadr < 32'(4 * DEPTH_WORDS));
   assign ram_we   = memwrite && aligned && in_ram;
   assign push_req = memwrite && aligned && (dataadr == FIFO_PUSH);
   assign end_req  = memwrite && aligned && (dataadr == TEST_END);

   always_ff @(posedge clk) begin
      if (!reset && ram_we) RAM[widx] <= writedata;
   end

   always_comb begin
      readdata = '0;
      if (in_ram)
         readdata = RAM[widx];
      else if (dataadr == FIFO_STAT)
         readdata = 32'(f_count);
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (out_ready),
      .din   (writedata),
      .dout  (out_data),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   assign out_valid = !f_empty;

   // First verdict wins; flags are sticky until reset.
   always_comb begin
      done_d = done_q;
      pass_d = pass_q;
      ovf_d  = ovf_q;
      mis_d  = mis_q;
      if (memwrite && !aligned) mis_d = 1'b1;
      if (push_req && f_full && !(out_ready && !f_empty)) ovf_d = 1'b1;
      if (end_req && !done_q) begin
         done_d = 1'b1;
         pass_d = (writedata == PASS_CODE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
         pass_q <= 1'b0;
         ovf_q  <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         pass_q <= pass_d;
         ovf_q  <= ovf_d;
         mis_q  <= mis_d;
      end
   end

   assign done     = done_q;
   assign pass     = pass_q;
   assign overflow = ovf_q;
   assign misalign = mis_q;

endmodule

// File: doc/mmio_dmem.md
MMIO_DMEM -- requirements
Module: mmio_dmem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: data RAM size in 32-bit words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: result FIFO entries, a power of two.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port memwrite, input, 1: CPU store strobe, valid for the current cycle.
REQ-006 SHALL have port dataadr, input, 32: CPU byte address.
REQ-007 SHALL have port writedata, input, 32: CPU store data.
REQ-008 SHALL have port readdata, output, 32: CPU load data, combinational.
REQ-009 SHALL have port out_valid, output, 1: result FIFO is non-empty.
REQ-010 SHALL have port out_data, output, 32: FIFO head word.
REQ-011 SHALL have port out_ready, input, 1: sink accepts the head word.
REQ-012 SHALL have port done, output, 1: test-end flag, sticky.
REQ-013 SHALL have port pass, output, 1: test verdict, meaningful only while done=1.
REQ-014 SHALL have port overflow, output, 1: sticky; a FIFO push was dropped.
REQ-015 SHALL have port misalign, output, 1: sticky; a store had dataadr[1:0]!=0.

Function
REQ-016 SHALL decode the RAM region as dataadr < 4*DEPTH_WORDS, word index dataadr[log2(DEPTH_WORDS)+1:2].
REQ-017 SHALL decode FIFO_PUSH=0xFFFFFFF0, FIFO_STAT=0xFFFFFFF4 and TEST_END=0xFFFFFFFC; all other addresses SHALL be unmapped.
REQ-018 SHALL write RAM on the posedge when memwrite=1, the address is aligned and it is in the RAM region, with the new value readable in the next cycle.
REQ-019 SHALL drive readdata from the addressed RAM word, {28'b0,count} at FIFO_STAT, and 0 at every other address, with no clock latency.
REQ-020 SHALL drop a store with dataadr[1:0]!=0 to any address, set misalign, and cause no other side effect.
REQ-021 SHALL silently ignore stores to unmapped addresses.
REQ-022 SHALL push writedata into the FIFO on an aligned store to FIFO_PUSH.
REQ-023 SHALL pop the FIFO on a posedge where out_valid=1 and out_ready=1.
REQ-024 SHALL have out_data and out_valid reflect a push to an empty FIFO one cycle later, with no same-cycle bypass.
REQ-025 SHALL, when the FIFO is full and a pop coincides with a push, perform both and leave count unchanged.
REQ-026 SHALL, when the FIFO is full with no pop, drop the push, set overflow, and leave the contents intact.
REQ-027 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with count ranging 0..FIFO_DEPTH.
REQ-028 SHALL, on the first aligned store to TEST_END, set done=1 and set pass=(writedata==32'd1).
REQ-029 SHALL ignore later TEST_END stores while done=1 (the first verdict wins).
REQ-030 SHALL keep the FIFO and RAM operating after done is set.

Reset
REQ-031 SHALL clear the FIFO pointers, count, out_valid, done, pass, overflow and misalign on a posedge with reset=1.
REQ-032 SHALL NOT clear RAM contents on reset, so preloaded images persist.
REQ-033 SHALL give reset priority over a simultaneous memwrite or pop, which have no effect in that cycle.
REQ-034 SHALL, when reset is asserted mid-stream, discard pending FIFO entries and drive out_valid=0 in the next cycle.
REQ-035 SHALL drive readdata from RAM/decode during reset (the combinational path is unaffected).

Structure
REQ-036 SHALL place FIFO_PUSH, FIFO_STAT, TEST_END and the PASS_CODE=1 constant in package mmio_dmem_pkg.
REQ-037 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-038 SHALL keep the RAM array and address decode in mmio_dmem, with the RAM exposed as array RAM for hierarchical preload.

Verification
REQ-039 SHALL cover: store 88 to 0x54, then load 0x54 -> readdata=88 next cycle; RAM[21]=88.
REQ-040 SHALL cover: store to 0x55 -> misalign=1 and RAM unchanged; load 0x54 still returns the prior value.
REQ-041 SHALL cover: 8 pushes with out_ready=0, then a 9th push -> overflow=1, count=8, and FIFO_STAT reads 8; draining yields the first 8 values in order.
REQ-042 SHALL cover: a full FIFO with simultaneous push and pop -> count stays 8, the popped value is the oldest, and the new value is last.
REQ-043 SHALL cover: store 1 then 0 to 0xFFFFFFFC -> done=1 and pass=1 after the first store, unchanged after the second; store 7 first -> pass=0.
REQ-044 SHALL cover: reset asserted with 3 entries queued -> out_valid=0, done=0 and flags cleared next cycle; RAM[21] still 88.
